sumsq_seq: RTL and testbench
============================

// Module: sumsq_seq
// PURPOSE
//  Serial sum-of-squares stage: takes a signed vector sample (x, y) and computes x*x + y*y
//  with a one-bit-per-cycle shift-add squarer.
//  Sits directly upstream of the digit-by-digit integer square root. Its 32-bit result is the
//  radicand `data`, so the pair yields the vector magnitude.
//  Valid/ready on both sides; holds its result until the consumer accepts it.
// PARAMETERS
//  IN_W   16        width of signed x, y inputs (>=2)
//  OUT_W  2*IN_W    width of the unsigned sum; derived, not to be overridden
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      x, y valid
//  in_ready   out  1      block can accept a sample
//  x          in   IN_W   signed component
//  y          in   IN_W   signed component
//  out_valid  out  1      data valid
//  out_ready  in   1      downstream accepts data
//  data       out  OUT_W  unsigned x*x + y*y
// BEHAVIOUR
//  Reset (async assert, sync release):
//    state=IDLE, in_ready=1, out_valid=0, data=0; counter and accumulator cleared.
//  States:
//    IDLE -> SQ_X on in_valid&&in_ready.
//      At that edge latch ax=|x|, ay=|y| as IN_W-bit unsigned (|-2^(IN_W-1)| = 2^(IN_W-1)).
//      Clear acc and cnt.
//    SQ_X, IN_W cycles: if ax[cnt], acc += ax<<cnt; cnt++.
//      On cnt==IN_W-1 go to SQ_Y with cnt=0.
//    SQ_Y, IN_W cycles: same operation with ay.
//      On the last one go to DONE: data<=final acc, out_valid<=1.
//    DONE -> IDLE on out_ready: out_valid<=0 at that edge.
//  Latency: out_valid rises exactly 2*IN_W clock edges after the accept edge (32 for IN_W=16).
//  Throughput: one sample per 2*IN_W+2 cycles when out_ready is held high.
//  in_ready = (state==IDLE), registered-state decode only; no combinational path from out_ready.
//  in_valid in non-IDLE states is ignored. x and y are sampled only at the accept edge.
//  Input changes during SQ_X/SQ_Y do not affect the result.
//  data is stable while out_valid=1 and out_ready=0, for any stall length.
//  data keeps its last value after the handshake, until the next DONE.
//  Widths: acc is OUT_W bits. Worst case 2*2^(2*IN_W-2) = 2^(OUT_W-1), so no overflow and no saturation.
//  rst_n low mid-operation: abort immediately, all outputs take reset values, no partial result is emitted.
//  No simultaneous in/out handshake: in_ready is 0 in DONE.
// STRUCTURE
//  Shared package isqrt_pkg:
//    typedef enum logic [1:0] {IDLE, SQ_X, SQ_Y, DONE} sumsq_state_e;
//    localparam int ISQRT_IN_W = 16.
//  One sub-module, serial_sq_step:
//    combinational add of (operand[cnt] ? operand<<cnt : 0) into acc;
//    instanced once and time-shared between x and y.
//  Top holds the FSM, the $clog2(IN_W) counter, acc, and the output register.
// TESTING
//  x=3, y=4, out_ready=1 -> data=25. out_valid high exactly 32 edges after accept, for 1 cycle.
//  x=-32768, y=-32768 -> data=32'h8000_0000.
//  x=32767, y=-1 -> data=1073676290.
//  x=0, y=0 -> data=0.
//  x=15528, y=0 -> data=241118784. Chained into the square-root stage, q=15528.
//  Backpressure and reset:
//    hold out_ready=0 for 5 cycles after out_valid -> data stable, in_ready=0.
//    Then out_ready=1 -> in_ready=1 next cycle.
//    Pulse rst_n low 10 cycles after accept -> out_valid=0, in_ready=1 at once.
//    Next sample x=5, y=12 -> data=169.
//  Back-to-back: in_valid held with changing x, y -> one result per 34 cycles.
//    Each result matches the operands present at its accept edge.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared definitions for the magnitude pipeline (sum-of-squares stage and the
// digit-by-digit integer square root that consumes its result).
//   sumsq_state_e : control states of the serial sum-of-squares stage
//   ISQRT_IN_W    : default component width of the vector samples
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_X = 2'd1,
    SQ_Y = 2'd2,
    DONE = 2'd3
  } sumsq_state_e;

  localparam int ISQRT_IN_W = 16;

endpackage

// File: rtl/serial_sq_step.sv
// One shift-add step of a serial squarer.
//   operand  in   IN_W    unsigned magnitude being squared
//   cnt      in   CNT_W   bit position examined in this step
//   acc      in   OUT_W   running partial sum
//   acc_next out  OUT_W   acc + (operand[cnt] ? operand << cnt : 0)
// Purely combinational; the caller time-shares it between both components.
module serial_sq_step
  import isqrt_pkg::*;
#(
  parameter int IN_W  = ISQRT_IN_W,
  parameter int OUT_W = 2 * IN_W,
  parameter int CNT_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  operand,
  input  logic [CNT_W-1:0] cnt,
  input  logic [OUT_W-1:0] acc,
  output logic [OUT_W-1:0] acc_next
);

  logic [OUT_W-1:0] operand_ext_s;
  logic [OUT_W-1:0] partial_s;

  // Conditionally add the shifted operand (one partial product per step).
  always_comb begin
    operand_ext_s = {{(OUT_W-IN_W){1'b0}}, operand};
    if (operand[cnt]) begin
      partial_s = operand_ext_s << cnt;
    end else begin
      partial_s = {OUT_W{1'b0}};
    end
    acc_next = acc + partial_s;
  end

endmodule

// File: rtl/sumsq_seq.sv
// Serial sum-of-squares stage: data = x*x + y*y, one partial product per cycle.
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake; x, y sampled only at the accept edge
//   x, y                 signed IN_W-bit components
//   out_valid/out_ready  output handshake; data held until accepted
//   data                 unsigned OUT_W-bit sum of squares
// Result appears 2*IN_W edges after accept; x is squared first, then y, both
// through a single shared shift-add step. The OUT_W accumulator cannot
// overflow: the largest sum is exactly 2^(OUT_W-1).
module sumsq_seq
  import isqrt_pkg::*;
#(
  parameter  int IN_W  = ISQRT_IN_W,
  localparam int OUT_W = 2 * IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data
);

  localparam int CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0]  IN_ONE   = IN_W'(1);

  sumsq_state_e     state_r,     state_nx_s;
  logic [CNT_W-1:0] cnt_r,       cnt_nx_s;
  logic [OUT_W-1:0] acc_r,       acc_nx_s;
  logic [IN_W-1:0]  ax_r,        ax_nx_s;
  logic [IN_W-1:0]  ay_r,        ay_nx_s;
  logic [OUT_W-1:0] data_r,      data_nx_s;
  logic             out_valid_r, out_valid_nx_s;
  logic             in_ready_r,  in_ready_nx_s;
  logic [IN_W-1:0]  step_operand_s;
  logic [OUT_W-1:0] step_acc_s;

  // Two's-complement magnitude as unsigned; the most negative value maps to
  // 2^(IN_W-1), which still fits in IN_W unsigned bits.
  function automatic logic [IN_W-1:0] abs_u(input logic [IN_W-1:0] v);
    if (v[IN_W-1]) begin
      abs_u = ~v + IN_ONE;
    end else begin
      abs_u = v;
    end
  endfunction

  serial_sq_step #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_step (
    .operand  (step_operand_s),
    .cnt      (cnt_r),
    .acc      (acc_r),
    .acc_next (step_acc_s)
  );

  // Next-state, datapath and output-register logic for the control FSM.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    acc_nx_s       = acc_r;
    ax_nx_s        = ax_r;
    ay_nx_s        = ay_r;
    data_nx_s      = data_r;
    out_valid_nx_s = out_valid_r;
    in_ready_nx_s  = in_ready_r;

    if (state_r == SQ_Y) begin
      step_operand_s = ay_r;
    end else begin
      step_operand_s = ax_r;
    end

    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_nx_s    = SQ_X;
          ax_nx_s       = abs_u(x);
          ay_nx_s       = abs_u(y);
          acc_nx_s      = {OUT_W{1'b0}};
          cnt_nx_s      = {CNT_W{1'b0}};
          in_ready_nx_s = 1'b0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SQ_X: begin
        acc_nx_s = step_acc_s;
        if (cnt_r == CNT_LAST) begin
          state_nx_s = SQ_Y;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      SQ_Y: begin
        acc_nx_s = step_acc_s;
        if (cnt_r == CNT_LAST) begin
          state_nx_s     = DONE;
          cnt_nx_s       = {CNT_W{1'b0}};
          data_nx_s      = step_acc_s;
          out_valid_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        // in_ready stays low here, so a new sample can only be taken after
        // the result has been handed off.
        if (out_ready) begin
          state_nx_s     = IDLE;
          out_valid_nx_s = 1'b0;
          in_ready_nx_s  = 1'b1;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s     = IDLE;
        out_valid_nx_s = 1'b0;
        in_ready_nx_s  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= {OUT_W{1'b0}};
      ax_r        <= {IN_W{1'b0}};
      ay_r        <= {IN_W{1'b0}};
      data_r      <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      acc_r       <= acc_nx_s;
      ax_r        <= ax_nx_s;
      ay_r        <= ay_nx_s;
      data_r      <= data_nx_s;
      out_valid_r <= out_valid_nx_s;
      in_ready_r  <= in_ready_nx_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign data      = data_r;

endmodule

// File: tb/tb_sumsq_seq.sv
// Self-checking bench for sumsq_seq (IN_W = 16): directed cases from the
// component values of interest, backpressure, mid-operation reset,
// randomized samples and back-to-back streaming against an arithmetic model.
module tb_sumsq_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data;

  int checks;
  int errors;

  sumsq_seq #(.IN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed arithmetic on the sampled components.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 32'(sa * sa + sb * sb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one sample, scramble inputs afterwards, measure latency, check result.
  task automatic run_one(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [31:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    x = xv;
    y = yv;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_data"}, 64'(data), 64'(exp));
    tick();
    chk({tag, "_one_cycle"}, 64'(out_valid), 64'd0);
    chk({tag, "_held"}, 64'(data), 64'(exp));
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] ry;
    logic [31:0] hold;
    logic [31:0] exp_q[$];
    int n;
    int outs;
    int last_out;

    checks = 0;
    errors = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = 16'd0;
    y = 16'd0;
    rst_n = 1'b0;
    #23;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    rst_n = 1'b1;
    tick();

    run_one("x3y4", 16'd3, 16'd4, 32'd25);
    run_one("minmin", 16'h8000, 16'h8000, 32'h8000_0000);
    run_one("max_m1", 16'd32767, 16'hFFFF, 32'd1073676290);
    run_one("zero", 16'd0, 16'd0, 32'd0);
    run_one("q15528", 16'd15528, 16'd0, 32'd241118784);

    // Backpressure: result must hold for a 5-cycle stall.
    x = 16'd100;
    y = 16'hFF9C;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd32);
    hold = model(16'd100, 16'hFF9C);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", 64'(data), 64'(hold));
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);

    // Reset 10 cycles into an operation: abort, no partial result.
    x = 16'd1234;
    y = 16'd4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'(data), 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_no_result", 64'(out_valid), 64'd0);
    run_one("x5y12", 16'd5, 16'd12, 32'd169);

    // Randomized samples, including the extreme codes.
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i == 0) rx = 16'h8000;
      if (i == 1) ry = 16'h7FFF;
      run_one("rand", rx, ry, model(rx, ry));
    end

    // Back-to-back with in_valid held and operands changing every cycle.
    out_ready = 1'b1;
    in_valid = 1'b1;
    outs = 0;
    last_out = -1;
    n = 0;
    while (outs < 4 && n < 400) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      x = rx;
      y = ry;
      // in_ready only changes on edges, so its value now is what the next edge sees.
      if (in_ready) exp_q.push_back(model(rx, ry));
      tick();
      n++;
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          chk("b2b_data", 64'(data), 64'(exp_q.pop_front()));
        end else begin
          chk("b2b_unexpected", 64'd1, 64'(exp_q.size()));
        end
        if (last_out >= 0) chk("b2b_spacing", 64'(n - last_out), 64'd34);
        last_out = n;
        outs++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 64'(outs), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
